// File: rtl/line_mem_responder.sv
// Line-granular main-memory responder for the L1 miss path.
// Optional LINE_MEM_PATTERN_INIT_EN: reset loads a deterministic pattern into the array.
module line_mem_responder #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 9,
    parameter int LATENCY       = 50
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_LEN-1:0] addr,
    input  logic                rd_req,
    input  logic                wr_req,
    input  logic [31:0]         wr_line [2**LINE_ADDR_LEN],
    output logic                gnt,
    output logic [31:0]         rd_line [2**LINE_ADDR_LEN]
);

    localparam int WORDS = 2**LINE_ADDR_LEN;
    localparam int LINES = 2**ADDR_LEN;
    localparam int CW    = $clog2(LATENCY + 1);

    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        GNT
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic                wr_op_q, wr_op_d;
    logic [31:0]         line_q [WORDS];
    logic [31:0]         line_d [WORDS];
    logic                gnt_q;
    logic [31:0]         rd_line_q [WORDS];

    logic [31:0]         mem_q [LINES][WORDS];

    // Array access performed on the edge that enters GNT
    logic                mem_we;
    logic                mem_re;
    logic [ADDR_LEN-1:0] acc_addr;
    logic [31:0]         acc_line [WORDS];

    // Next-state logic: accept, count down, abort, complete
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wr_op_d  = wr_op_q;
        line_d   = line_q;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        acc_addr = addr_q;
        acc_line = line_q;
        unique case (state_q)
            IDLE: begin
                if (wr_req || rd_req) begin
                    addr_d  = addr;
                    wr_op_d = wr_req;
                    line_d  = wr_line;
                    cnt_d   = CNT_LOAD;
                    if (LATENCY == 1) begin
                        // Single-cycle latency completes on the accept edge
                        state_d  = GNT;
                        acc_addr = addr;
                        acc_line = wr_line;
                        mem_we   = wr_req;
                        mem_re   = !wr_req;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (wr_op_q ? !wr_req : !rd_req) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = GNT;
                        mem_we  = wr_op_q;
                        mem_re  = !wr_op_q;
                    end
                end
            end
            GNT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control, capture and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wr_op_q <= 1'b0;
            gnt_q   <= 1'b0;
            for (int w = 0; w < WORDS; w++) begin
                line_q[w]    <= '0;
                rd_line_q[w] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_op_q <= wr_op_d;
            gnt_q   <= (state_d == GNT);
            for (int w = 0; w < WORDS; w++) begin
                line_q[w] <= line_d[w];
                if (mem_re) begin
                    rd_line_q[w] <= mem_q[acc_addr][w];
                end
            end
        end
    end

`ifdef LINE_MEM_PATTERN_INIT_EN
    // Storage array, reset to {line address, word index}
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < LINES; a++) begin
                for (int w = 0; w < WORDS; w++) begin
                    mem_q[a][w] <= {24'(a), 8'(w)};
                end
            end
        end else if (mem_we) begin
            for (int w = 0; w < WORDS; w++) begin
                mem_q[acc_addr][w] <= acc_line[w];
            end
        end
    end
`else
    // Storage array, contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int w = 0; w < WORDS; w++) begin
                mem_q[acc_addr][w] <= acc_line[w];
            end
        end
    end
`endif

    assign gnt     = gnt_q;
    assign rd_line = rd_line_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder (LATENCY=50 and LATENCY=1 instances).
// Honours LINE_MEM_PATTERN_INIT_EN when it is defined for the build.
module tb_line_mem_responder;

    localparam int LAT = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  addr = '0;
    logic        rd_req = 1'b0;
    logic        wr_req = 1'b0;
    logic [31:0] wr_line [8];
    logic        gnt;
    logic [31:0] rd_line [8];

    logic [8:0]  l1_addr = '0;
    logic        l1_rd_req = 1'b0;
    logic        l1_wr_req = 1'b0;
    logic [31:0] l1_wr_line [8];
    logic        l1_gnt;
    logic [31:0] l1_rd_line [8];

    logic [31:0] wdata [8];

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          wr;
        logic [8:0]  a;
        logic [31:0] base;
        logic [31:0] exp0;
        logic [31:0] exp7;
    } vec_t;

    vec_t vecs [12];

    line_mem_responder #(
        .LINE_ADDR_LEN(3),
        .ADDR_LEN(9),
        .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .addr(addr),
        .rd_req(rd_req),
        .wr_req(wr_req),
        .wr_line(wr_line),
        .gnt(gnt),
        .rd_line(rd_line)
    );

    line_mem_responder #(
        .LINE_ADDR_LEN(3),
        .ADDR_LEN(9),
        .LATENCY(1)
    ) dut1 (
        .clk(clk),
        .rst(rst),
        .addr(l1_addr),
        .rd_req(l1_rd_req),
        .wr_req(l1_wr_req),
        .wr_line(l1_wr_line),
        .gnt(l1_gnt),
        .rd_line(l1_rd_line)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [31:0] base);
        for (int w = 0; w < 8; w++) wdata[w] = base + 32'(w);
    endtask

    task automatic fill_pat(input logic [8:0] a);
        for (int w = 0; w < 8; w++) wdata[w] = {15'd0, a, 8'(w)};
    endtask

    // Presents a request and returns the number of cycles until gnt (-1 on timeout)
    task automatic run_req(input bit wr, input logic [8:0] a, output int lat);
        addr    = a;
        wr_req  = wr;
        rd_req  = !wr;
        wr_line = wdata;
        lat     = -1;
        for (int k = 1; k <= LAT + 20; k++) begin
            step();
            if (gnt) begin
                lat = k;
                break;
            end
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
    endtask

    initial begin
        int lat;
        int lat2;
        bit seen;

        vecs[0]  = '{1'b1, 9'h1F0, 32'h000000A0, 32'h00000500, 32'h00000507};
        vecs[1]  = '{1'b0, 9'h1F0, 32'h0,        32'h000000A0, 32'h000000A7};
        vecs[2]  = '{1'b1, 9'h0AB, 32'hDEAD0000, 32'h000000A0, 32'h000000A7};
        vecs[3]  = '{1'b1, 9'h154, 32'h12345670, 32'h000000A0, 32'h000000A7};
        vecs[4]  = '{1'b0, 9'h0AB, 32'h0,        32'hDEAD0000, 32'hDEAD0007};
        vecs[5]  = '{1'b0, 9'h154, 32'h0,        32'h12345670, 32'h12345677};
        vecs[6]  = '{1'b1, 9'h1FF, 32'hFFFFFFF0, 32'h12345670, 32'h12345677};
        vecs[7]  = '{1'b1, 9'h000, 32'h11110000, 32'h12345670, 32'h12345677};
        vecs[8]  = '{1'b0, 9'h1FF, 32'h0,        32'hFFFFFFF0, 32'hFFFFFFF7};
        vecs[9]  = '{1'b0, 9'h000, 32'h0,        32'h11110000, 32'h11110007};
        vecs[10] = '{1'b1, 9'h1F0, 32'h55550000, 32'h11110000, 32'h11110007};
        vecs[11] = '{1'b0, 9'h1F0, 32'h0,        32'h55550000, 32'h55550007};

        fill(32'h0);
        wr_line    = wdata;
        l1_wr_line = wdata;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
`ifndef LINE_MEM_PATTERN_INIT_EN
        // Array is not reset in this build: preload the lines the tests read
        fill_pat(9'h005);
        run_req(1'b1, 9'h005, lat);
        step();
        fill_pat(9'h022);
        run_req(1'b1, 9'h022, lat);
        step();
        fill_pat(9'h033);
        run_req(1'b1, 9'h033, lat);
        step();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
`endif

        check("reset_gnt", {31'd0, gnt}, 32'd0);
        check("reset_rd_line0", rd_line[0], 32'h0);
        check("reset_rd_line7", rd_line[7], 32'h0);

        // Read of a pattern line straight out of reset
        run_req(1'b0, 9'h005, lat);
        check("pat_latency", lat, LAT);
        check("pat_word3", rd_line[3], 32'h00000503);
        step();
        check("pat_gnt_pulse", {31'd0, gnt}, 32'd0);
        check("pat_hold1", rd_line[3], 32'h00000503);
        step();
        check("pat_hold2", rd_line[3], 32'h00000503);

        // Table of reads/writes, each started the cycle after the previous gnt
        for (int i = 0; i < 12; i++) begin
            fill(vecs[i].base);
            run_req(vecs[i].wr, vecs[i].a, lat);
            check($sformatf("vec%0d_latency", i), lat, LAT);
            check($sformatf("vec%0d_word0", i), rd_line[0], vecs[i].exp0);
            check($sformatf("vec%0d_word7", i), rd_line[7], vecs[i].exp7);
            step();
            check($sformatf("vec%0d_gnt_pulse", i), {31'd0, gnt}, 32'd0);
        end

        // Swap: write then read presented on the write's gnt cycle
        fill(32'h77770000);
        run_req(1'b1, 9'h011, lat);
        fill(32'h0);
        run_req(1'b0, 9'h022, lat2);
        check("swap_wr_latency", lat, LAT);
        check("swap_rd_latency", lat2, LAT + 1);
        check("swap_rd_word1", rd_line[1], 32'h00002201);
        seen = 1'b0;
        for (int k = 0; k < LAT + 5; k++) begin
            step();
            if (gnt) seen = 1'b1;
        end
        check("swap_no_extra_gnt", {31'd0, seen}, 32'd0);
        run_req(1'b0, 9'h011, lat);
        check("swap_wr_data", rd_line[5], 32'h77770005);
        step();

        // Abort: read dropped 10 cycles after acceptance
        addr   = 9'h1FF;
        rd_req = 1'b1;
        seen   = 1'b0;
        for (int k = 0; k < 11; k++) begin
            step();
            if (gnt) seen = 1'b1;
        end
        rd_req = 1'b0;
        for (int k = 0; k < LAT + 10; k++) begin
            step();
            if (gnt) seen = 1'b1;
        end
        check("abort_no_gnt", {31'd0, seen}, 32'd0);
        check("abort_rd_line", rd_line[0], 32'h77770000);
        run_req(1'b0, 9'h0AB, lat);
        check("after_abort_latency", lat, LAT);
        check("after_abort_word2", rd_line[2], 32'hDEAD0002);
        step();

        // Reset in the middle of a write
        fill(32'hBAD00000);
        wr_line = wdata;
        addr    = 9'h033;
        wr_req  = 1'b1;
        repeat (5) step();
        rst    = 1'b1;
        wr_req = 1'b0;
        #1;
        check("rst_mid_gnt", {31'd0, gnt}, 32'd0);
        step();
        check("rst_mid_gnt_held", {31'd0, gnt}, 32'd0);
        check("rst_mid_rd_line", rd_line[0], 32'h0);
        rst = 1'b0;
        step();
        run_req(1'b0, 9'h033, lat);
        check("rst_mid_latency", lat, LAT);
        check("rst_mid_word2", rd_line[2], 32'h00003302);

        // LATENCY=1 instance with both requests high: write wins
        for (int w = 0; w < 8; w++) l1_wr_line[w] = 32'hCC000000 + 32'(w);
        l1_addr   = 9'h044;
        l1_wr_req = 1'b1;
        l1_rd_req = 1'b1;
        step();
        check("l1_gnt", {31'd0, l1_gnt}, 32'd1);
        check("l1_rd_line_kept", l1_rd_line[0], 32'h0);
        l1_wr_req = 1'b0;
        l1_rd_req = 1'b0;
        step();
        check("l1_gnt_pulse", {31'd0, l1_gnt}, 32'd0);
        l1_rd_req = 1'b1;
        step();
        check("l1_rd_gnt", {31'd0, l1_gnt}, 32'd1);
        check("l1_rd_word6", l1_rd_line[6], 32'hCC000006);
        l1_rd_req = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_mem_responder.md
# line_mem_responder

Line-granular main-memory responder for the L1 cache miss path. Accepts one line read or line write from the cache controller, completes it after a fixed latency, and signals completion with a one-cycle `gnt` pulse. Read data is returned as a full line (2^LINE_ADDR_LEN words). It is the memory-side end of the cache's swap-in/swap-out protocol.

## Interface
- `LINE_ADDR_LEN`, 3: log2 of words per line.
- `ADDR_LEN`, 9: line address width; capacity is 2^ADDR_LEN lines.
- `LATENCY`, 50: cycles from request acceptance to `gnt`; legal range 1..255.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `addr`  in  ADDR_LEN  line address ({tag, set}).
- `rd_req`  in  1  line read request; level, held until `gnt`.
- `wr_req`  in  1  line write request; level, held until `gnt`.
- `wr_line`  in  32 x 2^LINE_ADDR_LEN  unpacked array, line to write.
- `gnt`  out  1  one-cycle completion pulse.
- `rd_line`  out  32 x 2^LINE_ADDR_LEN  unpacked array, last line read.

## Operation
- Storage: 2^ADDR_LEN x 2^LINE_ADDR_LEN x 32-bit array, line-wide read and write only.
- FSM states: IDLE, BUSY, GNT.
- IDLE: if `wr_req` or `rd_req` is high, capture `addr`, op (write if `wr_req` is high, else read), and `wr_line`. Load counter with LATENCY-1 and go to BUSY. If LATENCY=1, go directly to GNT.
- Write has priority when both requests are high. The controller never does this, but the behaviour is defined.
- BUSY: decrement counter. At 0, go to GNT. On that same edge:
  - write: commit captured line to the array;
  - read: load `rd_line` from the array at the captured address.
- GNT: `gnt`=1 for exactly this cycle, then unconditionally IDLE. A request still high during the GNT cycle is not accepted. The requester changes state on the edge that samples `gnt`.
- Captured values are used; changes on `addr`/`wr_line` after acceptance are ignored.
- Abort: if the captured op's request is low during BUSY, return to IDLE. No `gnt`, no array write, `rd_line` unchanged.
- `rd_line` holds its value until the next read completes. Writes never change it.
- Counter width: $clog2(LATENCY+1); no wrap is possible.

## Timing
- Reset values:
  - `gnt`=0, `rd_line` all words 0;
  - FSM IDLE, counter 0, capture registers 0;
  - array per Configuration.
- Reset mid-operation: immediate return to IDLE. No pending write is committed and no `gnt` is issued.
- Latency: request first seen high in IDLE in cycle t gives `gnt` high in cycle t+LATENCY. `rd_line` is valid from cycle t+LATENCY onward.
- Back-to-back requests: a write `gnt` in cycle g followed by a read presented in cycle g+1 is accepted in g+1. That read's `gnt` comes in g+1+LATENCY.
- Read-after-write to the same address returns the written line.
- `gnt` is registered; no combinational path from inputs to outputs.

## Configuration
- `LINE_MEM_PATTERN_INIT_EN` defined: on reset, array word w of line a is set to {a zero-extended to 24 bits, w zero-extended to 8 bits}. This gives deterministic content for miss tests.
- Not defined: the array is not reset and powers up/holds unknown or previous content. Only the FSM, counter, `gnt` and `rd_line` are reset.

## Test plan
- Pattern init, LATENCY=50: reset, `rd_req`=1 with `addr`=9'h005 from cycle 0. Required: `gnt` high only in cycle 50; `rd_line[3]`=32'h00000503; `rd_line` stable for ≥2 cycles after `gnt`.
- Write then read: write `addr`=9'h1F0 with words 32'hA0+i, then read the same address in the cycle after the write's `gnt`. Required: read `gnt` exactly LATENCY cycles later with `rd_line[i]`=32'hA0+i.
- Back-to-back swap: write to 9'h011, then on the `gnt` edge switch to `rd_req` at 9'h022 (the cache's SWAP_OUT to SWAP_IN sequence). Required: exactly two `gnt` pulses, 2*LATENCY+1 cycles apart from start; the request is not double-accepted.
- Abort: drop `rd_req` 10 cycles after acceptance. Required: no `gnt`; `rd_line` unchanged; the next request completes normally.
- Reset mid-write: assert `rst` during BUSY of a write to 9'h033. Required: `gnt`=0 immediately; a subsequent read of 9'h033 returns the pattern value, not the written data.
- LATENCY=1 with both `rd_req` and `wr_req` high. Required: `gnt` in cycle 1; the write is performed and `rd_line` is unchanged.
